milley_observer: RTL and testbench



---
 rtl/milley_observer.sv | 99 +++++++++
 tb/tb_milley_observer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/milley_observer.sv
// Receive-side observer for the 2-bit Mealy encoder (states C1..C4).
// Tracks the set of encoder states consistent with the symbol stream and decodes inputs.
module milley_observer (
  input  logic       clk,
  input  logic       reset,
  input  logic       sym_valid,
  input  logic [1:0] sym,
  output logic       dec_valid,
  output logic [1:0] dec_a,
  output logic       dec_ambig,
  output logic       dec_err,
  output logic [3:0] state_set,
  output logic       locked,
  output logic [7:0] err_cnt
);

  localparam int unsigned NUM_TRANS = 9;
  localparam int unsigned SET_W     = 4;
  localparam int unsigned CNT_W     = 8;

  typedef struct packed {
    logic [1:0]       src;  // source state index: 0=C1 .. 3=C4
    logic [1:0]       sym;
    logic [SET_W-1:0] dst;  // one-hot next state
    logic [1:0]       din;  // decoded input
  } trans_t;

  // Encoder emission table; C4/B2 appears twice because it is inherently ambiguous.
  function automatic trans_t table_entry(input int unsigned idx);
    trans_t e;
    case (idx)
      0:       e = '{src: 2'd0, sym: 2'b01, dst: 4'b0001, din: 2'b00};
      1:       e = '{src: 2'd0, sym: 2'b10, dst: 4'b0010, din: 2'b10};
      2:       e = '{src: 2'd0, sym: 2'b11, dst: 4'b0100, din: 2'b11};
      3:       e = '{src: 2'd1, sym: 2'b00, dst: 4'b0001, din: 2'b11};
      4:       e = '{src: 2'd2, sym: 2'b00, dst: 4'b1000, din: 2'b01};
      5:       e = '{src: 2'd2, sym: 2'b10, dst: 4'b0001, din: 2'b10};
      6:       e = '{src: 2'd2, sym: 2'b11, dst: 4'b0010, din: 2'b11};
      7:       e = '{src: 2'd3, sym: 2'b01, dst: 4'b1000, din: 2'b01};
      default: e = '{src: 2'd3, sym: 2'b01, dst: 4'b0010, din: 2'b11};
    endcase
    return e;
  endfunction

  trans_t           entry;
  logic             hit;
  logic             ambig;
  logic [1:0]       in_acc;
  logic [SET_W-1:0] cand;

  // Evaluate every candidate state against the incoming symbol.
  always_comb begin
    entry  = '0;
    hit    = 1'b0;
    ambig  = 1'b0;
    in_acc = 2'b00;
    cand   = '0;
    for (int unsigned i = 0; i < NUM_TRANS; i++) begin
      entry = table_entry(i);
      if (state_set[entry.src] && (entry.sym == sym)) begin
        cand = cand | entry.dst;
        if (!hit) begin
          hit    = 1'b1;
          in_acc = entry.din;
        end else if (entry.din != in_acc) begin
          ambig = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_set <= SET_W'(1);
      dec_valid <= 1'b0;
      dec_a     <= 2'b00;
      dec_ambig <= 1'b0;
      dec_err   <= 1'b0;
      err_cnt   <= '0;
    end else if (sym_valid) begin
      dec_valid <= 1'b1;
      dec_a     <= (hit && !ambig) ? in_acc : 2'b00;
      dec_ambig <= hit && ambig;
      dec_err   <= !hit;
      // An impossible symbol means we lost track; resync to every state.
      state_set <= hit ? cand : {SET_W{1'b1}};
      if (!hit && (err_cnt != {CNT_W{1'b1}}))
        err_cnt <= err_cnt + CNT_W'(1);
    end else begin
      dec_valid <= 1'b0;
      dec_a     <= 2'b00;
      dec_ambig <= 1'b0;
      dec_err   <= 1'b0;
    end
  end

  assign locked = $onehot(state_set);

endmodule

// File: tb/tb_milley_observer.sv
// Directed bench for milley_observer: hand-derived decode results for known symbol streams.
module tb_milley_observer;

  logic       clk = 1'b0;
  logic       reset;
  logic       sym_valid;
  logic [1:0] sym;
  logic       dec_valid;
  logic [1:0] dec_a;
  logic       dec_ambig;
  logic       dec_err;
  logic [3:0] state_set;
  logic       locked;
  logic [7:0] err_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  milley_observer dut (
    .clk(clk), .reset(reset), .sym_valid(sym_valid), .sym(sym),
    .dec_valid(dec_valid), .dec_a(dec_a), .dec_ambig(dec_ambig), .dec_err(dec_err),
    .state_set(state_set), .locked(locked), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Observed vector layout: {dec_valid, dec_a[1:0], dec_ambig, dec_err, state_set[3:0], locked}
  function automatic logic [9:0] obs();
    return {dec_valid, dec_a, dec_ambig, dec_err, state_set, locked};
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; sym_valid = 1'b0; sym = 2'b00;
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Present one symbol; sample #1 after the capturing edge.
  task automatic send(input logic [1:0] s);
    @(negedge clk);
    sym_valid = 1'b1; sym = s;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    @(negedge clk);
    sym_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (obs() !== 10'b0_00_0_0_0001_1 || err_cnt !== 8'd0)
      $display("FAIL reset_state: got %b cnt=%0d, want 0000000011 cnt=0", obs(), err_cnt);
    else n_pass++;
  endtask

  task automatic test_decode_path();
    logic [1:0] syms [4] = '{2'b11, 2'b00, 2'b01, 2'b00};
    logic [9:0] exp  [4] = '{10'b1_11_0_0_0100_1, 10'b1_01_0_0_1000_1,
                             10'b1_00_1_0_1010_0, 10'b1_11_0_0_0001_1};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      send(syms[i]);
      n_checks++;
      if (obs() !== exp[i])
        $display("FAIL decode_path[%0d]: got %b want %b", i, obs(), exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_self_loop();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      send(2'b01);
      n_checks++;
      if (obs() !== 10'b1_00_0_0_0001_1)
        $display("FAIL self_loop[%0d]: got %b want 1000000011", i, obs());
      else n_pass++;
    end
  endtask

  task automatic test_error_resync();
    apply_reset();
    send(2'b00);
    n_checks++;
    if (obs() !== 10'b1_00_0_1_1111_0 || err_cnt !== 8'd1)
      $display("FAIL err_resync: got %b cnt=%0d want 1000111110 cnt=1", obs(), err_cnt);
    else n_pass++;
    send(2'b10);
    n_checks++;
    if (obs() !== 10'b1_10_0_0_0011_0)
      $display("FAIL after_resync_b3: got %b want 1100000110", obs());
    else n_pass++;
  endtask

  task automatic test_ambig_full_set();
    apply_reset();
    send(2'b00);
    send(2'b01);
    n_checks++;
    if (obs() !== 10'b1_00_1_0_1011_0)
      $display("FAIL ambig_full_set: got %b want 1001010110", obs());
    else n_pass++;
  endtask

  task automatic test_sparse();
    int pulses = 0;
    logic [1:0] s;
    logic [9:0] e;
    apply_reset();
    for (int g = 0; g < 6; g++) begin
      s = (g % 2 == 0) ? 2'b10 : 2'b00;
      e = (g % 2 == 0) ? 10'b1_10_0_0_0010_1 : 10'b1_11_0_0_0001_1;
      send(s);
      if (dec_valid === 1'b1) pulses++;
      n_checks++;
      if (obs() !== e) $display("FAIL sparse_sym[%0d]: got %b want %b", g, obs(), e);
      else n_pass++;
      for (int k = 0; k < g; k++) begin
        idle();
        if (dec_valid === 1'b1) pulses++;
        n_checks++;
        if (obs() !== {5'b0_00_0_0, e[4:0]})
          $display("FAIL sparse_gap[%0d.%0d]: got %b want %b", g, k, obs(), {5'b0_00_0_0, e[4:0]});
        else n_pass++;
      end
    end
    n_checks++;
    if (pulses != 6) $display("FAIL sparse_pulses: got %0d want 6", pulses);
    else n_pass++;
  endtask

  // Each round: B1 from {C1} is impossible; B1,B3,B1 walks {all} back to {C1}.
  task automatic test_saturation();
    int exp_cnt;
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      send(2'b00);
      exp_cnt = (i + 1 > 255) ? 255 : i + 1;
      n_checks++;
      if (obs() !== 10'b1_00_0_1_1111_0 || err_cnt !== 8'(exp_cnt))
        $display("FAIL saturation[%0d]: got %b cnt=%0d want 1000111110 cnt=%0d",
                 i, obs(), err_cnt, exp_cnt);
      else n_pass++;
      send(2'b00);
      send(2'b10);
      send(2'b00);
    end
    n_checks++;
    if (obs() !== 10'b1_11_0_0_0001_1 || err_cnt !== 8'd255)
      $display("FAIL saturation_walk: got %b cnt=%0d want 1110000011 cnt=255", obs(), err_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_midburst();
    send(2'b11);
    @(negedge clk);
    reset = 1'b1; sym_valid = 1'b1; sym = 2'b00;
    @(posedge clk); #1;
    n_checks++;
    if (obs() !== 10'b0_00_0_0_0001_1 || err_cnt !== 8'd0)
      $display("FAIL reset_midburst: got %b cnt=%0d want 0000000011 cnt=0", obs(), err_cnt);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0; sym_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (obs() !== 10'b0_00_0_0_0001_1)
      $display("FAIL post_reset_idle: got %b want 0000000011", obs());
    else n_pass++;
  endtask

  initial begin
    reset = 1'b1; sym_valid = 1'b0; sym = 2'b00;
    test_reset();
    test_decode_path();
    test_self_loop();
    test_error_resync();
    test_ambig_full_set();
    test_sparse();
    test_saturation();
    test_reset_midburst();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
